// File: rtl/layer_2_conv.sv
// layer_2_conv: second convolution stage. Buffers one 3x3 window of two signed
// 18-bit Q.10 channels from layer 1, runs NUM_FILT filters over it using an
// external synchronous weight ROM, and emits one ReLU'd, saturated result per filter.
// Ports: clk/rst (async active-high), tx_done (sync frame clear), din_0/din_1/din_vld
// (tap input), bsy (to layer-1 bsy_in), wgt_addr/wgt_0/wgt_1 (weight ROM, 1-cycle read),
// bsy_in (downstream stall), dout/dout_ch/dout_vld (result strobe).
// Optional: define L2_CONV_BIAS_EN to add the signed 18-bit per-filter bias input.
module layer_2_conv #(
  parameter int NUM_FILT  = 4,
  parameter int FRAC_BITS = 10,
  parameter int ACC_W     = 40,
  parameter int WADDR_W   = 8,
  localparam int CH_W     = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_done,
  input  logic [17:0]        din_0,
  input  logic [17:0]        din_1,
  input  logic               din_vld,
  output logic               bsy,
  output logic [WADDR_W-1:0] wgt_addr,
  input  logic [17:0]        wgt_0,
  input  logic [17:0]        wgt_1,
`ifdef L2_CONV_BIAS_EN
  input  logic [17:0]        bias,
`endif
  input  logic               bsy_in,
  output logic [17:0]        dout,
  output logic [CH_W-1:0]    dout_ch,
  output logic               dout_vld
);

  typedef enum logic [1:0] {CAPT, MAC, LAST, OUT} state_t;

  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(131071);

  state_t                    state_q, state_d;
  logic [3:0]                tap_q, tap_d;
  logic [CH_W-1:0]           filt_q, filt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [17:0]               res_q, res_d;
  logic                      bsy_q, bsy_d;
  logic [WADDR_W-1:0]        waddr_q, waddr_d;
  logic [17:0]               dout_q, dout_d;
  logic [CH_W-1:0]           dout_ch_q, dout_ch_d;
  logic                      dout_vld_q, dout_vld_d;
  logic                      cap_en;

  logic [17:0]               buf0_q [9];
  logic [17:0]               buf1_q [9];

  logic [3:0]                mac_idx;
  logic signed [35:0]        prod0, prod1;
  logic signed [ACC_W-1:0]   mac_sum;
  logic signed [ACC_W-1:0]   preload;
  logic signed [ACC_W-1:0]   acc_shr;

  // Weights arrive one cycle after their address, so MAC cycle k consumes tap k-1
  // and LAST consumes tap 8.
  assign mac_idx = (state_q == MAC && tap_q != 4'd0) ? tap_q - 4'd1 : 4'd8;
  assign prod0   = $signed(buf0_q[mac_idx]) * $signed(wgt_0);
  assign prod1   = $signed(buf1_q[mac_idx]) * $signed(wgt_1);
  assign mac_sum = {{(ACC_W-36){prod0[35]}}, prod0} + {{(ACC_W-36){prod1[35]}}, prod1};

`ifdef L2_CONV_BIAS_EN
  // Bias is in the data format, so align it with the Q.20 product sum.
  assign preload = {{(ACC_W-18){bias[17]}}, bias} << FRAC_BITS;
`else
  assign preload = '0;
`endif

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    filt_d     = filt_q;
    acc_d      = acc_q;
    res_d      = res_q;
    waddr_d    = waddr_q;
    dout_d     = dout_q;
    dout_ch_d  = dout_ch_q;
    dout_vld_d = 1'b0;
    cap_en     = 1'b0;
    acc_shr    = '0;
    bsy_d      = bsy_q;

    if (tx_done) begin
      // Frame clear: drop the window (and any coincident tap) without a strobe.
      state_d   = CAPT;
      tap_d     = '0;
      filt_d    = '0;
      acc_d     = '0;
      res_d     = '0;
      waddr_d   = '0;
      dout_d    = '0;
      dout_ch_d = '0;
    end else begin
      case (state_q)
        CAPT: begin
          if (din_vld) begin
            cap_en = 1'b1;
            if (tap_q == 4'd8) begin
              tap_d   = '0;
              filt_d  = '0;
              waddr_d = '0;
              state_d = MAC;
            end else begin
              tap_d = tap_q + 4'd1;
            end
          end
        end
        MAC: begin
          if (tap_q == 4'd0) begin
            acc_d = preload;
          end else begin
            acc_d = acc_q + mac_sum;
          end
          if (tap_q == 4'd8) begin
            tap_d   = '0;
            state_d = LAST;
          end else begin
            tap_d   = tap_q + 4'd1;
            waddr_d = waddr_q + WADDR_W'(1);
          end
        end
        LAST: begin
          acc_d   = acc_q + mac_sum;
          acc_shr = acc_d >>> FRAC_BITS;
          if (acc_shr[ACC_W-1]) begin
            res_d = '0;
          end else if (acc_shr > RES_MAX) begin
            res_d = 18'h1FFFF;
          end else begin
            res_d = acc_shr[17:0];
          end
          state_d = OUT;
        end
        OUT: begin
          // Hold res until downstream accepts; the filter only advances on a strobe.
          if (!bsy_in) begin
            dout_d     = res_q;
            dout_ch_d  = filt_q;
            dout_vld_d = 1'b1;
            if (filt_q == CH_W'(NUM_FILT - 1)) begin
              filt_d  = '0;
              state_d = CAPT;
            end else begin
              filt_d  = filt_q + CH_W'(1);
              waddr_d = WADDR_W'((32'(filt_q) + 1) * 9);
              state_d = MAC;
            end
          end
        end
        default: state_d = CAPT;
      endcase
    end

    // Registered from the next state so bsy is already high in the cycle after
    // tap 8 is captured, when layer 1 samples it.
    bsy_d = (state_d != CAPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CAPT;
      tap_q      <= '0;
      filt_q     <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      bsy_q      <= 1'b0;
      waddr_q    <= '0;
      dout_q     <= '0;
      dout_ch_q  <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      filt_q     <= filt_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      bsy_q      <= bsy_d;
      waddr_q    <= waddr_d;
      dout_q     <= dout_d;
      dout_ch_q  <= dout_ch_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  // Window buffer carries no reset: it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      buf0_q[tap_q] <= din_0;
      buf1_q[tap_q] <= din_1;
    end
  end

  assign bsy      = bsy_q;
  assign wgt_addr = waddr_q;
  assign dout     = dout_q;
  assign dout_ch  = dout_ch_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_layer_2_conv.sv
// tb_layer_2_conv: directed, table-driven bench for layer_2_conv with a
// synchronous weight ROM model and a strobe monitor.
module tb_layer_2_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_done = 1'b0;
  logic [17:0] din_0 = '0;
  logic [17:0] din_1 = '0;
  logic        din_vld = 1'b0;
  logic        bsy;
  logic [7:0]  wgt_addr;
  logic [17:0] wgt_0 = '0;
  logic [17:0] wgt_1 = '0;
  logic        bsy_in = 1'b0;
  logic [17:0] dout;
  logic [1:0]  dout_ch;
  logic        dout_vld;
`ifdef L2_CONV_BIAS_EN
  logic [17:0] bias = '0;
`endif

  logic [17:0] rom0 [256];
  logic [17:0] rom1 [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_dout[$];
  int q_ch[$];
  int q_cyc[$];
  int q_addr[$];

  // One row per (window, filter): window taps are d0/d1 on all 9 positions,
  // filter weights w0/w1 on all 9 positions, exp is the expected dout.
  typedef struct packed {
    int d0;
    int d1;
    int w0;
    int w1;
    int exp;
  } row_t;
  row_t rows[24];

  layer_2_conv dut (
    .clk      (clk),
    .rst      (rst),
    .tx_done  (tx_done),
    .din_0    (din_0),
    .din_1    (din_1),
    .din_vld  (din_vld),
    .bsy      (bsy),
    .wgt_addr (wgt_addr),
    .wgt_0    (wgt_0),
    .wgt_1    (wgt_1),
`ifdef L2_CONV_BIAS_EN
    .bias     (bias),
`endif
    .bsy_in   (bsy_in),
    .dout     (dout),
    .dout_ch  (dout_ch),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    wgt_0 <= rom0[wgt_addr];
    wgt_1 <= rom1[wgt_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_vld) begin
        q_dout.push_back(int'(dout));
        q_ch.push_back(int'(dout_ch));
        q_cyc.push_back(cyc);
      end
      if (bsy) q_addr.push_back(int'(wgt_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_rom(input int w);
    for (int a = 0; a < 256; a++) begin
      rom0[a] = '0;
      rom1[a] = '0;
    end
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 9; k++) begin
        rom0[f*9+k] = 18'(rows[w*4+f].w0);
        rom1[f*9+k] = 18'(rows[w*4+f].w1);
      end
    end
  endtask

  task automatic send_taps(input int d0, input int d1, input int n);
    for (int i = 0; i < n; i++) begin
      din_0   = 18'(d0);
      din_1   = 18'(d1);
      din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
  endtask

  // Wait for four strobes and idle, then compare against the table.
  task automatic check_window(input int w, input int qb, input int mac_cyc);
    for (int i = 0; i < 400; i++) begin
      if (q_dout.size() >= qb + 4 && !bsy) break;
      tick();
    end
    chk("strobe_count", q_dout.size() - qb, 4);
    chk("bsy_idle", int'(bsy), 0);
    for (int f = 0; f < 4; f++) begin
      if (qb + f < q_dout.size()) begin
        chk($sformatf("w%0d_f%0d_dout", w, f), q_dout[qb+f], rows[w*4+f].exp);
        chk($sformatf("w%0d_f%0d_ch", w, f), q_ch[qb+f], f);
      end
    end
    if (mac_cyc >= 0 && q_cyc.size() > qb) chk("latency", q_cyc[qb] - mac_cyc, 11);
    tick();
    chk("bsy_after_last", int'(bsy), 0);
    chk("dout_hold", int'(dout), rows[w*4+3].exp);
  endtask

  initial begin
    int qb, ab, mc, nb, found, bad_vld, bad_bsy, amax, acount;
    logic [35:0] seen;

    rows[0]  = '{1024, 0, 1024, 0, 9216};
    rows[1]  = '{1024, 0, 0, 0, 0};
    rows[2]  = '{1024, 0, 0, 0, 0};
    rows[3]  = '{1024, 0, 0, 0, 0};
    rows[4]  = '{1024, 0, -1024, 0, 0};
    rows[5]  = '{1024, 0, 2048, 0, 18432};
    rows[6]  = '{1024, 0, 0, 5000, 0};
    rows[7]  = '{1024, 0, 1, 0, 9};
    rows[8]  = '{2048, 1024, 512, -512, 4608};
    rows[9]  = '{2048, 1024, -1024, 0, 0};
    rows[10] = '{2048, 1024, 0, 0, 0};
    rows[11] = '{2048, 1024, 1024, 1024, 27648};
    rows[12] = '{131071, 131071, 131071, 131071, 131071};
    rows[13] = '{131071, 131071, 131071, 0, 131071};
    rows[14] = '{131071, 131071, 14, 0, 16127};
    rows[15] = '{131071, 131071, -131071, -131071, 0};
    rows[16] = '{1024, 0, 14563, 0, 131067};
    rows[17] = '{1024, 0, 14564, 0, 131071};
    rows[18] = '{1024, 0, -1, 0, 0};
    rows[19] = '{1024, 0, 7, 0, 63};
    rows[20] = '{-1024, -2048, -1024, 0, 9216};
    rows[21] = '{-1024, -2048, 0, -512, 9216};
    rows[22] = '{-1024, -2048, 1024, 1024, 0};
    rows[23] = '{-1024, -2048, -3, 0, 27};

    load_rom(0);
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_bsy", int'(bsy), 0);
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_ch", int'(dout_ch), 0);
    chk("rst_wgt_addr", int'(wgt_addr), 0);
    rst = 1'b0;
    tick();
    chk("idle_bsy", int'(bsy), 0);

    // Table-driven windows.
    for (int w = 0; w < 6; w++) begin
      load_rom(w);
      qb = q_dout.size();
      ab = q_addr.size();
      send_taps(rows[w*4].d0, rows[w*4].d1, 9);
      mc = cyc;
      chk("bsy_after_tap8", int'(bsy), 1);
      if (w == 0) begin
        // A 10th tap while busy must not disturb buffered tap 0.
        din_0   = 18'(30000);
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
      end
      check_window(w, qb, mc);
      if (w == 0) begin
        seen   = '0;
        amax   = 0;
        acount = 0;
        for (int i = ab; i < q_addr.size(); i++) begin
          if (q_addr[i] > amax) amax = q_addr[i];
          if (q_addr[i] < 36) seen[q_addr[i]] = 1'b1;
        end
        for (int i = 0; i < 36; i++) acount += int'(seen[i]);
        chk("addr_cover", acount, 36);
        chk("addr_max", amax, 35);
      end
    end

    // Stall filter 1 in OUT for five cycles.
    load_rom(1);
    qb = q_dout.size();
    send_taps(rows[4].d0, rows[4].d1, 9);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (dout_vld) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("stall_first_strobe", found, 1);
    bsy_in  = 1'b1;
    bad_vld = 0;
    bad_bsy = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (dout_vld) bad_vld++;
      if (!bsy) bad_bsy++;
      if (i == 15) bsy_in = 1'b0;
    end
    chk("stall_no_vld", bad_vld, 0);
    chk("stall_bsy_low", bad_bsy, 0);
    tick();
    chk("stall_release_vld", int'(dout_vld), 1);
    chk("stall_release_dout", int'(dout), 18432);
    chk("stall_release_ch", int'(dout_ch), 1);
    check_window(1, qb, -1);

    // Abort at MAC k=4 of filter 2.
    load_rom(2);
    send_taps(rows[8].d0, rows[8].d1, 9);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (dout_vld && dout_ch == 2'd1) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("abort_ch1_seen", found, 1);
    repeat (4) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("abort_bsy", int'(bsy), 0);
    chk("abort_wgt_addr", int'(wgt_addr), 0);
    chk("abort_dout_vld", int'(dout_vld), 0);
    nb = q_dout.size();
    repeat (25) tick();
    chk("abort_no_strobe", q_dout.size() - nb, 0);

    // Partial window, then tx_done coinciding with a tap: tap counter must clear.
    send_taps(5000, 5000, 3);
    din_vld = 1'b1;
    tx_done = 1'b1;
    tick();
    din_vld = 1'b0;
    tx_done = 1'b0;
    chk("txd_din_bsy", int'(bsy), 0);
    load_rom(0);
    qb = q_dout.size();
    send_taps(rows[0].d0, rows[0].d1, 9);
    mc = cyc;
    chk("fresh_bsy", int'(bsy), 1);
    check_window(0, qb, mc);

    // Asynchronous reset mid-MAC.
    load_rom(3);
    send_taps(rows[12].d0, rows[12].d1, 9);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_bsy", int'(bsy), 0);
    chk("midrst_wgt_addr", int'(wgt_addr), 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef L2_CONV_BIAS_EN
    bias = 18'd100;
    load_rom(0);
    qb = q_dout.size();
    send_taps(rows[0].d0, rows[0].d1, 9);
    for (int i = 0; i < 400; i++) begin
      if (q_dout.size() >= qb + 4 && !bsy) break;
      tick();
    end
    chk("bias_count", q_dout.size() - qb, 4);
    if (q_dout.size() >= qb + 4) begin
      chk("bias_f0", q_dout[qb], 9316);
      chk("bias_f1", q_dout[qb+1], 100);
      chk("bias_f3", q_dout[qb+3], 100);
    end
    bias = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
